// File: rtl/alu_pkg.sv
// Shared opcode map, FSM encoding and opcode classification helpers
// for the ALU issue controller.
package alu_pkg;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_MULT  = 6'h04;
    localparam logic [5:0] OP_MULTI = 6'h05;
    localparam logic [5:0] OP_DIV   = 6'h06;
    localparam logic [5:0] OP_DIVI  = 6'h07;
    localparam logic [5:0] OP_MOD   = 6'h08;
    localparam logic [5:0] OP_XOR   = 6'h09;
    localparam logic [5:0] OP_SLTIU = 6'h13;
    localparam logic [5:0] OP_BEQ   = 6'h17;
    localparam logic [5:0] OP_BNE   = 6'h18;
    localparam logic [5:0] OP_OUT   = 6'h1C;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RESP
    } state_e;

    function automatic logic is_slow_op(input logic [5:0] op);
        return (op >= OP_MULT) && (op <= OP_MOD);
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op <= OP_SLTIU) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_OUT);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-side and response bundle of the ALU issue controller.
// slave is the controller side, master the requester/ALU side.
interface alu_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             reqValid;
    logic             reqReady;
    logic [5:0]       reqOp;
    logic [31:0]      reqA;
    logic [31:0]      reqB;
    logic [TAG_W-1:0] reqTag;
    logic [5:0]       aluOpCode;
    logic [31:0]      aluDataA;
    logic [31:0]      aluDataB;
    logic [31:0]      aluDataC;
    logic             aluBranch;
    logic             aluOverflow;
    logic             rspValid;
    logic             rspReady;
    logic [31:0]      rspData;
    logic             rspBranch;
    logic             rspError;
    logic [TAG_W-1:0] rspTag;
    logic             busy;
    logic             clearErr;
    logic [15:0]      errCount;

    modport slave (
        input  reqValid, reqOp, reqA, reqB, reqTag,
        input  aluDataC, aluBranch, aluOverflow,
        input  rspReady, clearErr,
        output reqReady, aluOpCode, aluDataA, aluDataB,
        output rspValid, rspData, rspBranch, rspError,
        output rspTag, busy, errCount
    );

    modport master (
        output reqValid, reqOp, reqA, reqB, reqTag,
        output aluDataC, aluBranch, aluOverflow,
        output rspReady, clearErr,
        input  reqReady, aluOpCode, aluDataA, aluDataB,
        input  rspValid, rspData, rspBranch, rspError,
        input  rspTag, busy, errCount
    );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: settle speed, legality and which
// ALU flags carry meaning for the opcode.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0] op,
    output logic       slow,
    output logic       legal,
    output logic       uses_ovf,
    output logic       is_branch,
    output logic       is_div_mod
);

    always_comb begin
        slow       = is_slow_op(op);
        legal      = is_legal_op(op);
        uses_ovf   = 1'b0;
        is_branch  = 1'b0;
        is_div_mod = 1'b0;
        unique case (1'b1)
            (op == OP_ADD), (op == OP_SUB),
            (op == OP_MULT), (op == OP_MULTI): uses_ovf = 1'b1;
            (op == OP_DIV), (op == OP_DIVI),
            (op == OP_MOD): is_div_mod = 1'b1;
            (op == OP_BEQ), (op == OP_BNE): is_branch = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential initiator for the combinational ALU: issue, settle,
// capture and return one request at a time over valid/ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int SETTLE_FST = 1,
    parameter int SETTLE_SLW = 4
) (
    input  logic             clock,
    input  logic             resetN,
    alu_issue_ctrl_if.slave  bus
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LD_FST = CNT_W'(SETTLE_FST - 1);
    localparam logic [CNT_W-1:0] LD_SLW = CNT_W'(SETTLE_SLW - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       op_q, op_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             legal_q, legal_d;
    logic             ovf_q, ovf_d;
    logic             br_q, br_d;
    logic             dm_q, dm_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic             rsp_branch_q, rsp_branch_d;
    logic             rsp_error_q, rsp_error_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    logic dec_slow, dec_legal, dec_ovf, dec_br, dec_dm;
    logic req_ready, accept, div_zero, cap_err, cap_zero;

    alu_op_decode u_dec (
        .op         (bus.reqOp),
        .slow       (dec_slow),
        .legal      (dec_legal),
        .uses_ovf   (dec_ovf),
        .is_branch  (dec_br),
        .is_div_mod (dec_dm)
    );

    always_comb begin
        req_ready = 1'b0;
        unique case (state_q)
            ST_IDLE:   req_ready = 1'b1;
            ST_SETTLE: req_ready = 1'b0;
            ST_RESP:   req_ready = bus.rspReady;
            default:   req_ready = 1'b0;
        endcase
    end

    assign accept   = bus.reqValid & req_ready;
    assign div_zero = dm_q & (b_q == 32'd0);
    // Flags are only trusted where the latched opcode gives them meaning
    assign cap_err  = ~legal_q | div_zero | (ovf_q & bus.aluOverflow);
    assign cap_zero = ~legal_q | div_zero | br_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        tag_d        = tag_q;
        legal_d      = legal_q;
        ovf_d        = ovf_q;
        br_d         = br_q;
        dm_d         = dm_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_branch_d = rsp_branch_q;
        rsp_error_d  = rsp_error_q;
        rsp_tag_d    = rsp_tag_q;
        err_cnt_d    = err_cnt_q;

        unique case (state_q)
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = cap_zero ? 32'd0 : bus.aluDataC;
                    rsp_branch_d = br_q & bus.aluBranch;
                    rsp_error_d  = cap_err;
                    rsp_tag_d    = tag_q;
                    state_d      = ST_RESP;
                    if (cap_err && err_cnt_q != 16'hFFFF)
                        err_cnt_d = err_cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            op_d    = bus.reqOp;
            a_d     = bus.reqA;
            b_d     = bus.reqB;
            tag_d   = bus.reqTag;
            legal_d = dec_legal;
            ovf_d   = dec_ovf;
            br_d    = dec_br;
            dm_d    = dec_dm;
            cnt_d   = dec_slow ? LD_SLW : LD_FST;
            state_d = ST_SETTLE;
        end

        if (bus.clearErr)
            err_cnt_d = 16'd0;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            tag_q        <= '0;
            legal_q      <= 1'b0;
            ovf_q        <= 1'b0;
            br_q         <= 1'b0;
            dm_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_branch_q <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_tag_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            tag_q        <= tag_d;
            legal_q      <= legal_d;
            ovf_q        <= ovf_d;
            br_q         <= br_d;
            dm_q         <= dm_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_branch_q <= rsp_branch_d;
            rsp_error_q  <= rsp_error_d;
            rsp_tag_q    <= rsp_tag_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.reqReady  = req_ready;
    assign bus.aluOpCode = op_q;
    assign bus.aluDataA  = a_q;
    assign bus.aluDataB  = b_q;
    assign bus.rspValid  = rsp_valid_q;
    assign bus.rspData   = rsp_data_q;
    assign bus.rspBranch = rsp_branch_q;
    assign bus.rspError  = rsp_error_q;
    assign bus.rspTag    = rsp_tag_q;
    assign bus.errCount  = err_cnt_q;
    assign bus.busy      = (state_q == ST_SETTLE) ||
                           (state_q == ST_RESP);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural ALU
// answering the registered opcode/operands.
module tb_alu_issue_ctrl;

    logic clock;
    logic resetN;
    int   n_vec;
    int   n_err;
    logic force_ovf;

    logic [31:0] m_c, m_s;
    logic        m_br, m_ov;

    alu_issue_ctrl_if #(.TAG_W(4)) bus ();

    alu_issue_ctrl #(
        .TAG_W      (4),
        .SETTLE_FST (1),
        .SETTLE_SLW (4)
    ) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    always_comb begin
        m_c  = 32'd0;
        m_s  = 32'd0;
        m_br = 1'b0;
        m_ov = 1'b0;
        case (bus.aluOpCode)
            6'h00: begin
                m_s  = bus.aluDataA + bus.aluDataB;
                m_c  = m_s;
                m_ov = (bus.aluDataA[31] == bus.aluDataB[31]) &&
                       (m_s[31] != bus.aluDataA[31]);
            end
            6'h01: begin
                m_s  = bus.aluDataA - bus.aluDataB;
                m_c  = m_s;
                m_ov = (bus.aluDataA[31] != bus.aluDataB[31]) &&
                       (m_s[31] != bus.aluDataA[31]);
            end
            6'h02: m_c = bus.aluDataA & bus.aluDataB;
            6'h03: m_c = bus.aluDataA | bus.aluDataB;
            6'h04: m_c = bus.aluDataA * bus.aluDataB;
            6'h06: m_c = (bus.aluDataB == 0) ? 32'hDEADBEEF :
                         bus.aluDataA / bus.aluDataB;
            6'h08: m_c = (bus.aluDataB == 0) ? 32'hDEADBEEF :
                         bus.aluDataA % bus.aluDataB;
            6'h17: begin
                m_br = (bus.aluDataA == bus.aluDataB);
                m_c  = 32'h1234;
            end
            6'h18: begin
                m_br = (bus.aluDataA != bus.aluDataB);
                m_c  = 32'h1234;
            end
            default: m_c = bus.aluDataA ^ bus.aluDataB;
        endcase
    end

    assign bus.aluDataC    = m_c;
    assign bus.aluBranch   = m_br;
    assign bus.aluOverflow = m_ov | force_ovf;

    task automatic send(input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag);
        bus.reqValid = 1'b1;
        bus.reqOp    = op;
        bus.reqA     = a;
        bus.reqB     = b;
        bus.reqTag   = tag;
        @(negedge clock);
        bus.reqValid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (bus.rspValid !== 1'b1 && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if (bus.reqReady !== 1'b1) begin
            n_err++;
            $display("FAIL rst_reqReady: got %b exp 1", bus.reqReady);
        end
        n_vec++;
        if (bus.rspValid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_rspValid: got %b exp 0", bus.rspValid);
        end
        n_vec++;
        if (bus.aluOpCode !== 6'h00 || bus.aluDataA !== 32'd0 ||
            bus.aluDataB !== 32'd0) begin
            n_err++;
            $display("FAIL rst_alu: got %h/%h/%h exp 0/0/0",
                     bus.aluOpCode, bus.aluDataA, bus.aluDataB);
        end
        n_vec++;
        if (bus.rspData !== 32'd0 || bus.rspTag !== 4'd0) begin
            n_err++;
            $display("FAIL rst_rsp: got %h/%h exp 0/0",
                     bus.rspData, bus.rspTag);
        end
        n_vec++;
        if (bus.errCount !== 16'd0) begin
            n_err++;
            $display("FAIL rst_errCount: got %h exp 0", bus.errCount);
        end
        n_vec++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_busy: got %b exp 0", bus.busy);
        end
    endtask

    task automatic test_add();
        int cyc;
        send(6'h00, 32'h10, 32'h20, 4'd3);
        wait_rsp(cyc);
        n_vec++;
        if (cyc != 1) begin
            n_err++;
            $display("FAIL add_latency: got %0d exp 1", cyc);
        end
        n_vec++;
        if (bus.rspData !== 32'h30 || bus.rspError !== 1'b0) begin
            n_err++;
            $display("FAIL add_rsp: got %h err %b exp 30 err 0",
                     bus.rspData, bus.rspError);
        end
        n_vec++;
        if (bus.rspTag !== 4'd3 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL add_tag_busy: got %h/%b exp 3/1",
                     bus.rspTag, bus.busy);
        end
        @(negedge clock);
        n_vec++;
        if (bus.rspValid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL add_done: got valid %b busy %b exp 0/0",
                     bus.rspValid, bus.busy);
        end
        send(6'h00, 32'h7FFFFFFF, 32'h1, 4'd4);
        wait_rsp(cyc);
        n_vec++;
        if (bus.rspError !== 1'b1 || bus.rspData !== 32'h80000000) begin
            n_err++;
            $display("FAIL add_ovf: got %h err %b exp 80000000 err 1",
                     bus.rspData, bus.rspError);
        end
        @(negedge clock);
        force_ovf = 1'b1;
        send(6'h03, 32'hF0, 32'h0F, 4'd5);
        wait_rsp(cyc);
        n_vec++;
        if (bus.rspError !== 1'b0 || bus.rspData !== 32'hFF) begin
            n_err++;
            $display("FAIL or_ovf_mask: got %h err %b exp ff err 0",
                     bus.rspData, bus.rspError);
        end
        force_ovf = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_div();
        int cyc;
        int bad;
        send(6'h06, 32'd100, 32'd0, 4'd1);
        wait_rsp(cyc);
        n_vec++;
        if (cyc != 4) begin
            n_err++;
            $display("FAIL div0_latency: got %0d exp 4", cyc);
        end
        n_vec++;
        if (bus.rspData !== 32'd0 || bus.rspError !== 1'b1) begin
            n_err++;
            $display("FAIL div0_rsp: got %h err %b exp 0 err 1",
                     bus.rspData, bus.rspError);
        end
        n_vec++;
        if (bus.errCount !== 16'd2) begin
            n_err++;
            $display("FAIL div0_errCount: got %0d exp 2", bus.errCount);
        end
        @(negedge clock);
        send(6'h06, 32'd100, 32'd7, 4'd2);
        cyc = 0;
        bad = 0;
        forever begin
            if (bus.aluOpCode !== 6'h06 || bus.aluDataA !== 32'd100 ||
                bus.aluDataB !== 32'd7)
                bad++;
            if (bus.rspValid === 1'b1 || cyc >= 20) break;
            @(negedge clock);
            cyc++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL div_alu_stable: got %0d unstable cycles exp 0",
                     bad);
        end
        n_vec++;
        if (cyc != 4) begin
            n_err++;
            $display("FAIL div_latency: got %0d exp 4", cyc);
        end
        n_vec++;
        if (bus.rspData !== 32'd14 || bus.rspError !== 1'b0) begin
            n_err++;
            $display("FAIL div_rsp: got %0d err %b exp 14 err 0",
                     bus.rspData, bus.rspError);
        end
        @(negedge clock);
    endtask

    task automatic test_branch();
        int cyc;
        send(6'h17, 32'd5, 32'd5, 4'd6);
        wait_rsp(cyc);
        n_vec++;
        if (bus.rspBranch !== 1'b1 || bus.rspData !== 32'd0) begin
            n_err++;
            $display("FAIL beq: got br %b data %h exp 1/0",
                     bus.rspBranch, bus.rspData);
        end
        @(negedge clock);
        send(6'h18, 32'd5, 32'd5, 4'd7);
        wait_rsp(cyc);
        n_vec++;
        if (bus.rspBranch !== 1'b0 || bus.rspError !== 1'b0) begin
            n_err++;
            $display("FAIL bne: got br %b err %b exp 0/0",
                     bus.rspBranch, bus.rspError);
        end
        @(negedge clock);
        send(6'h01, 32'd9, 32'd4, 4'd8);
        wait_rsp(cyc);
        n_vec++;
        if (bus.rspBranch !== 1'b0 || bus.rspData !== 32'd5 ||
            cyc != 1) begin
            n_err++;
            $display("FAIL sub: got br %b data %0d cyc %0d exp 0/5/1",
                     bus.rspBranch, bus.rspData, cyc);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad;
        bus.rspReady = 1'b0;
        send(6'h00, 32'd1, 32'd2, 4'd5);
        wait_rsp(cyc);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (bus.rspValid !== 1'b1 || bus.rspData !== 32'd3 ||
                bus.rspTag !== 4'd5 || bus.reqReady !== 1'b0)
                bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL hold_stable: got %0d bad cycles exp 0", bad);
        end
        bus.rspReady = 1'b1;
        bus.reqValid = 1'b1;
        bus.reqOp    = 6'h01;
        bus.reqA     = 32'd10;
        bus.reqB     = 32'd3;
        bus.reqTag   = 4'd6;
        #1;
        n_vec++;
        if (bus.reqReady !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: got %b exp 1", bus.reqReady);
        end
        @(negedge clock);
        bus.reqValid = 1'b0;
        n_vec++;
        if (bus.rspValid !== 1'b0 || bus.aluOpCode !== 6'h01 ||
            bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: got v %b op %h busy %b exp 0/01/1",
                     bus.rspValid, bus.aluOpCode, bus.busy);
        end
        wait_rsp(cyc);
        n_vec++;
        if (bus.rspData !== 32'd7 || bus.rspTag !== 4'd6 || cyc != 1) begin
            n_err++;
            $display("FAIL b2b_rsp: got %0d tag %0d cyc %0d exp 7/6/1",
                     bus.rspData, bus.rspTag, cyc);
        end
        @(negedge clock);
    endtask

    task automatic test_illegal();
        int cyc;
        send(6'h3F, 32'd1, 32'd2, 4'd9);
        wait_rsp(cyc);
        n_vec++;
        if (bus.rspError !== 1'b1 || bus.rspData !== 32'd0 ||
            cyc != 1) begin
            n_err++;
            $display("FAIL illegal: got err %b data %h cyc %0d exp 1/0/1",
                     bus.rspError, bus.rspData, cyc);
        end
        n_vec++;
        if (bus.errCount !== 16'd3) begin
            n_err++;
            $display("FAIL illegal_cnt: got %0d exp 3", bus.errCount);
        end
        @(negedge clock);
        force dut.err_cnt_q = 16'hFFFE;
        #1;
        release dut.err_cnt_q;
        @(negedge clock);
        send(6'h3F, 32'd0, 32'd0, 4'd1);
        wait_rsp(cyc);
        n_vec++;
        if (bus.errCount !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_reach: got %h exp ffff", bus.errCount);
        end
        @(negedge clock);
        send(6'h3F, 32'd0, 32'd0, 4'd2);
        wait_rsp(cyc);
        n_vec++;
        if (bus.errCount !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_hold: got %h exp ffff", bus.errCount);
        end
        @(negedge clock);
        send(6'h3F, 32'd0, 32'd0, 4'd3);
        bus.clearErr = 1'b1;
        wait_rsp(cyc);
        bus.clearErr = 1'b0;
        n_vec++;
        if (bus.errCount !== 16'd0 || bus.rspError !== 1'b1) begin
            n_err++;
            $display("FAIL clear_wins: got %h err %b exp 0/1",
                     bus.errCount, bus.rspError);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int cyc;
        int stale;
        send(6'h04, 32'd3, 32'd4, 4'd7);
        @(negedge clock);
        #2;
        resetN = 1'b0;
        #1;
        n_vec++;
        if (bus.aluOpCode !== 6'h00 || bus.aluDataA !== 32'd0 ||
            bus.aluDataB !== 32'd0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_rst_alu: got %h/%h/%h busy %b exp 0",
                     bus.aluOpCode, bus.aluDataA, bus.aluDataB, bus.busy);
        end
        n_vec++;
        if (bus.rspValid !== 1'b0 || bus.errCount !== 16'd0) begin
            n_err++;
            $display("FAIL mid_rst_rsp: got v %b cnt %h exp 0/0",
                     bus.rspValid, bus.errCount);
        end
        @(negedge clock);
        resetN = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (bus.rspValid !== 1'b0) stale++;
        end
        n_vec++;
        if (stale != 0) begin
            n_err++;
            $display("FAIL mid_rst_stale: got %0d valid cycles exp 0",
                     stale);
        end
        send(6'h00, 32'd7, 32'd8, 4'd2);
        wait_rsp(cyc);
        n_vec++;
        if (bus.rspData !== 32'd15 || bus.rspTag !== 4'd2 || cyc != 1) begin
            n_err++;
            $display("FAIL post_rst_add: got %0d tag %0d cyc %0d exp 15/2/1",
                     bus.rspData, bus.rspTag, cyc);
        end
        @(negedge clock);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        clock        = 1'b0;
        resetN       = 1'b0;
        force_ovf    = 1'b0;
        bus.reqValid = 1'b0;
        bus.reqOp    = 6'h00;
        bus.reqA     = 32'd0;
        bus.reqB     = 32'd0;
        bus.reqTag   = 4'd0;
        bus.rspReady = 1'b1;
        bus.clearErr = 1'b0;
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        #1;
        test_reset();
        @(negedge clock);
        test_add();
        test_div();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
